// File: rtl/alt_run_detector_if.sv
// Sample/result bundle for alt_run_detector.
//   valid_i, x_i, mode_i, clear_i : sample qualifier, bit, overlap mode, clear
//   y_o, run_len_o, last_bit_o, det_count_o : registered detector results
interface alt_run_detector_if #(
    parameter int unsigned RUN_W = 8,
    parameter int unsigned CNT_W = 16
);
    logic             valid_i;
    logic             x_i;
    logic             mode_i;
    logic             clear_i;
    logic             y_o;
    logic [RUN_W-1:0] run_len_o;
    logic             last_bit_o;
    logic [CNT_W-1:0] det_count_o;

    // Sample source side
    modport master (
        output valid_i, x_i, mode_i, clear_i,
        input  y_o, run_len_o, last_bit_o, det_count_o
    );

    // Detector side
    modport slave (
        input  valid_i, x_i, mode_i, clear_i,
        output y_o, run_len_o, last_bit_o, det_count_o
    );
endinterface

// File: rtl/alt_run_detector.sv
// Alternating-run detector: tracks the length of the current run of strictly
// alternating accepted samples and pulses y_o one cycle after the run reaches
// MIN_LEN (overlapping or non-overlapping), with a saturating detection count.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : sample inputs and registered results (alt_run_detector_if)
module alt_run_detector #(
    parameter int unsigned MIN_LEN = 3,
    parameter int unsigned RUN_W   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    alt_run_detector_if.slave  bus
);
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] MIN_V   = RUN_W'(MIN_LEN);

    logic [RUN_W-1:0] r_run;
    logic             r_last;
    logic             r_y;
    logic [CNT_W-1:0] r_cnt;

    logic [RUN_W-1:0] w_run_next;
    logic [RUN_W-1:0] w_run_d;
    logic             w_last_d;
    logic             w_det;
    logic [CNT_W-1:0] w_cnt_d;

    // Next-state for run length, last bit and counter on an accepted sample
    always_comb begin
        w_run_next = RUN_W'(1);
        w_det      = 1'b0;
        w_run_d    = r_run;
        w_last_d   = r_last;
        w_cnt_d    = r_cnt;

        // An empty history or a repeated bit restarts the run at this sample
        if ((r_run != '0) && (bus.x_i != r_last)) begin
            w_run_next = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
        end

        if (bus.valid_i) begin
            w_det    = bus.mode_i ? (w_run_next == MIN_V) : (w_run_next >= MIN_V);
            // Non-overlapping hits drop all history so the next sample starts fresh
            w_run_d  = (bus.mode_i && w_det) ? '0 : w_run_next;
            w_last_d = bus.x_i;
            if (w_det && (r_cnt != CNT_MAX)) begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers; clear behaves like reset and drops the sample
    always_ff @(posedge clk) begin
        if (reset || bus.clear_i) begin
            r_run  <= '0;
            r_last <= 1'b0;
            r_y    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_run  <= w_run_d;
            r_last <= w_last_d;
            r_y    <= w_det;
            r_cnt  <= w_cnt_d;
        end
    end

    assign bus.y_o         = r_y;
    assign bus.run_len_o   = r_run;
    assign bus.last_bit_o  = r_last;
    assign bus.det_count_o = r_cnt;
endmodule

// File: tb/tb_alt_run_detector.sv
// Testbench for alt_run_detector: two instances (default widths and a narrow
// RUN_W=3/CNT_W=2 build) share one stimulus stream; a queue-based reference
// model predicts each cycle's outputs and a monitor compares after each edge.
module tb_alt_run_detector;
    localparam int MIN_LEN = 3;

    typedef struct {
        bit y;
        int run;
        bit last;
        int cnt;
    } exp_t;

    logic clk;
    logic reset;

    alt_run_detector_if #(.RUN_W(8), .CNT_W(16)) if0 ();
    alt_run_detector_if #(.RUN_W(3), .CNT_W(2))  if1 ();

    alt_run_detector #(.MIN_LEN(MIN_LEN), .RUN_W(8), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave)
    );
    alt_run_detector #(.MIN_LEN(MIN_LEN), .RUN_W(3), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t expq0[$];
    exp_t expq1[$];

    // Reference model state: the bits of the current alternating run
    bit h0[$];
    bit h1[$];
    bit lb0, lb1;
    int c0, c1;

    task automatic model(input int idx, input bit rst, input bit clr,
                         input bit v, input bit x, input bit md);
        bit   h[$];
        bit   lb;
        int   cnt, runmax, cntmax, len;
        bit   det;
        exp_t e;
        if (idx == 0) begin
            h = h0; lb = lb0; cnt = c0; runmax = 255; cntmax = 65535;
        end else begin
            h = h1; lb = lb1; cnt = c1; runmax = 7;   cntmax = 3;
        end
        e.y = 1'b0;
        if (rst || clr) begin
            h.delete(); lb = 1'b0; cnt = 0;
        end else if (v) begin
            if (h.size() != 0 && h[h.size()-1] == x) h.delete();
            h.push_back(x);
            len = (h.size() > runmax) ? runmax : h.size();
            det = md ? (len == MIN_LEN) : (len >= MIN_LEN);
            if (md && det) h.delete();
            lb = x;
            if (det && cnt < cntmax) cnt++;
            e.y = det;
        end
        e.run  = (h.size() > runmax) ? runmax : h.size();
        e.last = lb;
        e.cnt  = cnt;
        if (idx == 0) begin
            h0 = h; lb0 = lb; c0 = cnt; expq0.push_back(e);
        end else begin
            h1 = h; lb1 = lb; c1 = cnt; expq1.push_back(e);
        end
    endtask

    // Apply one cycle of stimulus to both instances and record expectations
    task automatic drive(input bit rst, input bit clr, input bit v,
                         input bit x, input bit md);
        @(negedge clk);
        reset       = rst;
        if0.clear_i = clr; if0.valid_i = v; if0.x_i = x; if0.mode_i = md;
        if1.clear_i = clr; if1.valid_i = v; if1.x_i = x; if1.mode_i = md;
        model(0, rst, clr, v, x, md);
        model(1, rst, clr, v, x, md);
    endtask

    task automatic sample(input bit x, input bit md);
        drive(1'b0, 1'b0, 1'b1, x, md);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input int d, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d got %0d want %0d", name, d, cyc, got, want);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared after the edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (expq0.size() != 0) begin
            e = expq0.pop_front();
            chk("y_o",         0, int'(if0.y_o),         int'(e.y));
            chk("run_len_o",   0, int'(if0.run_len_o),   e.run);
            chk("last_bit_o",  0, int'(if0.last_bit_o),  int'(e.last));
            chk("det_count_o", 0, int'(if0.det_count_o), e.cnt);
        end
        if (expq1.size() != 0) begin
            e = expq1.pop_front();
            chk("y_o",         1, int'(if1.y_o),         int'(e.y));
            chk("run_len_o",   1, int'(if1.run_len_o),   e.run);
            chk("last_bit_o",  1, int'(if1.last_bit_o),  int'(e.last));
            chk("det_count_o", 1, int'(if1.det_count_o), e.cnt);
        end
    end

    initial begin
        bit s1[5];
        bit s2[5];
        bit x;
        bit md;
        s1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        s2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        reset = 1'b1;
        if0.clear_i = 1'b0; if0.valid_i = 1'b0; if0.x_i = 1'b0; if0.mode_i = 1'b0;
        if1.clear_i = 1'b0; if1.valid_i = 1'b0; if1.x_i = 1'b0; if1.mode_i = 1'b0;

        // Reset then idle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // 0,1,0 overlapping
        sample(1'b0, 1'b0); sample(1'b1, 1'b0); sample(1'b0, 1'b0);
        idle(1);

        // 1,0,1,0,1 overlapping, then non-overlapping plus a sixth sample
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sample(s1[i], 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sample(s1[i], 1'b1);
        sample(1'b0, 1'b1);
        idle(1);

        // Break with random gaps between samples
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(int'($urandom_range(0, 3)));
            sample(s2[i], 1'b0);
        end
        idle(2);

        // Clear together with a valid sample at run length 2
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sample(1'b1, 1'b0); sample(1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        sample(1'b0, 1'b0);

        // Reset mid-run with a valid sample
        sample(1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sample(1'b1, 1'b0);

        // Saturation: 12 alternating samples in overlapping mode
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) sample(i[0], 1'b0);
        idle(1);

        // Mode switch mid-run with run above MIN_LEN
        for (int i = 0; i < 6; i++) sample(i[0], 1'b1);
        sample(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) sample(i[0], 1'b1);

        // Randomised traffic
        x  = 1'b0;
        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 75) x = ~x;
            if ($urandom_range(0, 99) < 3) md = ~md;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < 70, x, md);
        end
        idle(3);

        @(negedge clk);
        if (expq0.size() != 0 || expq1.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d/%0d want 0", expq0.size(), expq1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alt_run_detector.md
Name: alt_run_detector

Overview:
- Parametrised successor to the fixed 3-sample alternating-bit FSM.
- Watches a qualified serial bit stream and tracks the length of the current run of strictly alternating bits (…0101…).
- Flags when that run reaches a configurable minimum length, in overlapping or non-overlapping mode.
- Keeps a saturating detection counter; sits after line sampling logic in the serial front-end.

Parameters:
- MIN_LEN, 3: alternating samples required to flag; legal range 2 .. 2**RUN_W-1.
- RUN_W, 8: width of the run-length tracker and run_len_o.
- CNT_W, 16: width of the saturating detection counter det_count_o.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  x_i carries a sample this cycle.
- x_i  input  1  serial sample bit.
- mode_i  input  1  0 = overlapping, 1 = non-overlapping.
- clear_i  input  1  synchronous clear of run history, y_o and counter.
- y_o  output  1  registered one-cycle detection pulse.
- run_len_o  output  RUN_W  current alternating run length (registered).
- last_bit_o  output  1  last accepted sample bit.
- det_count_o  output  CNT_W  saturating count of detections.

Behaviour:
- Reset: synchronous, active-high, highest priority. Sets y_o=0, run_len_o=0, last_bit_o=0, det_count_o=0.
- clear_i (when not in reset): same effect as reset. If clear_i and valid_i are both high, clear wins and the sample is discarded.
- Cycles with valid_i=0: no state change; y_o=0 the following cycle. Gaps do not break a run.
- On an accepted sample (valid_i=1, no reset, no clear), compute run_next:
  - run==0 (no history): run_next=1.
  - x_i != last_bit: run_next = run+1, saturating at 2**RUN_W-1.
  - x_i == last_bit: run_next=1 (run restarts at this sample).
  - det = (run_next >= MIN_LEN).
- Overlapping mode (mode_i=0):
  - run <= run_next; det fires on every sample while the run stays alternating at or above MIN_LEN.
- Non-overlapping mode (mode_i=1):
  - det = (run_next == MIN_LEN).
  - On det, run <= 0, so the next sample starts fresh with no history; otherwise run <= run_next.
- Every accepted sample updates last_bit_o <= x_i, including in the non-overlap det case.
- y_o <= det, registered. Latency is exactly one cycle after the completing sample; y_o is a single-cycle pulse per detection.
- det_count_o increments by 1 per det and holds at 2**CNT_W-1 when saturated.
- mode_i is sampled per accepted sample. A change mid-run applies to the next accepted sample using the existing run value, with no flush.
  - Consequence: switching to mode 1 with run >= MIN_LEN gives no det until the run breaks and rebuilds to exactly MIN_LEN.
- Conditions in MIN_LEN=3, mode 0 that map to the original FSM's 010/101 outputs appear one cycle later on y_o.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/idle: assert reset 2 cycles, then valid_i=0 for 5 cycles -> all outputs 0, y_o never high.
- MIN_LEN=3, mode 0, accepted samples 0,1,0 -> y_o=1 exactly in the cycle after the third sample; run_len_o=3; det_count_o=1.
- MIN_LEN=3, stream 1,0,1,0,1:
  - mode 0 -> y_o pulses after samples 3, 4 and 5; det_count_o=3; run_len_o=5.
  - mode 1 -> y_o pulses after sample 3 only; run_len_o goes 0,1,2 after samples 3,4,5; a sixth alternating sample 0 gives a second pulse.
- Breaks and gaps: stream 1,0,0,1,0 with valid_i=0 bubbles of 0–3 cycles between samples -> run_len_o=1 after the repeated 0; single y_o pulse after the fifth sample; bubbles never change run_len_o.
- Priority:
  - clear_i and valid_i high together with run_len_o=2 -> run_len_o=0, det_count_o=0, sample ignored; next sample gives run_len_o=1.
  - reset asserted mid-run -> same result.
- Saturation: CNT_W=2, RUN_W=3, mode 0, 12 alternating samples ->
  - det_count_o holds 3.
  - run_len_o holds 7.
  - y_o continues pulsing for every sample from the third onward.
